// File: rtl/output_packer.sv
// Packs 32-bit pixels into 64-bit RIFFA TX words through a show-ahead FIFO,
// framing each output transfer with a req/ack handshake and a done pulse.
module output_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 info_valid,
  input  logic [31:0]          total_pixels,
  input  logic [PIX_W-1:0]     pixel_in,
  input  logic                 pixel_valid,
  output logic                 tx_req,
  input  logic                 tx_ack,
  output logic [31:0]          tx_len,
  output logic [30:0]          tx_off,
  output logic                 tx_last,
  output logic [2*PIX_W-1:0]   tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ren,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} state_t;

  state_t               state;
  logic [31:0]          total_lat;
  logic [31:0]          words_total;
  logic [31:0]          pix_cnt;
  logic [31:0]          word_cnt;
  logic [PIX_W-1:0]     low_half;
  logic [2*PIX_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic                 empty;
  logic                 full;
  logic                 accept;
  logic                 drop;
  logic                 last_pix;
  logic                 word_due;
  logic                 wr;
  logic                 rd;
  logic                 word_lost;
  logic [2*PIX_W-1:0]   word_data;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign accept    = pixel_valid && (state == REQ || state == STREAM) && (pix_cnt < total_lat);
  assign drop      = pixel_valid && !accept;
  assign last_pix  = ((pix_cnt + 32'd1) == total_lat);
  // Odd pixel completes a pair; an even pixel that is also the last goes out zero-padded.
  assign word_due  = accept && (pix_cnt[0] || last_pix);
  assign word_data = pix_cnt[0] ? {pixel_in, low_half} : {{PIX_W{1'b0}}, pixel_in};

  assign tx_data_valid = (state == STREAM) && !empty;
  assign tx_data       = tx_data_valid ? mem[rd_ptr] : '0;
  assign rd            = tx_data_valid && tx_data_ren;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign wr            = word_due && (!full || rd);
  assign word_lost     = word_due && full && !rd;

  assign tx_off  = '0;
  assign tx_last = 1'b1;

  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= word_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      total_lat   <= '0;
      words_total <= '0;
      pix_cnt     <= '0;
      word_cnt    <= '0;
      low_half    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_req      <= 1'b0;
      tx_len      <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (drop || word_lost) overflow <= 1'b1;

      if (accept) begin
        pix_cnt <= pix_cnt + 32'd1;
        if (!pix_cnt[0] && !last_pix) low_half <= pixel_in;
      end

      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr, rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (info_valid && total_pixels != 32'd0) begin
            total_lat   <= total_pixels;
            words_total <= {1'b0, total_pixels[31:1]} + {31'b0, total_pixels[0]};
            tx_len      <= total_pixels + {31'b0, total_pixels[0]};
            pix_cnt     <= '0;
            word_cnt    <= '0;
            // A pixel dropped on this same edge keeps the flag set.
            overflow    <= drop;
            tx_req      <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (tx_ack) begin
            tx_req <= 1'b0;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (rd) begin
            word_cnt <= word_cnt + 32'd1;
            if ((word_cnt + 32'd1) == words_total) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_packer.sv
// Directed bench for output_packer: framing, packing order, odd totals,
// FIFO saturation, idle drops, mid-frame reset and zero-length frames.
module tb_output_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        info_valid;
  logic [31:0] total_pixels;
  logic [31:0] pixel_in;
  logic        pixel_valid;
  logic        tx_req;
  logic        tx_ack;
  logic [31:0] tx_len;
  logic [30:0] tx_off;
  logic        tx_last;
  logic [63:0] tx_data;
  logic        tx_data_valid;
  logic        tx_data_ren;
  logic        frame_done;
  logic        overflow;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int          done_cnt  = 0;
  bit          req_seen  = 1'b0;
  logic [63:0] words[$];

  output_packer #(.FIFO_DEPTH(16), .PIX_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .info_valid    (info_valid),
    .total_pixels  (total_pixels),
    .pixel_in      (pixel_in),
    .pixel_valid   (pixel_valid),
    .tx_req        (tx_req),
    .tx_ack        (tx_ack),
    .tx_len        (tx_len),
    .tx_off        (tx_off),
    .tx_last       (tx_last),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ren   (tx_data_ren),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  // Inputs change just after posedge, so negedge values are what the next edge sees.
  always @(negedge clock) begin
    if (!reset) begin
      if (tx_data_valid && tx_data_ren) words.push_back(tx_data);
      if (frame_done) done_cnt++;
      if (tx_req) req_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] getw(input int k);
    if (k < words.size()) return words[k];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    words.delete();
    done_cnt = 0;
    req_seen = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    info_valid   = 1'b0;
    total_pixels = '0;
    pixel_in     = '0;
    pixel_valid  = 1'b0;
    tx_ack       = 1'b0;
    tx_data_ren  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] n);
    total_pixels = n;
    info_valid   = 1'b1;
    tick();
    info_valid   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 30 && done_cnt == 0; i++) tick();
    chk(tag, done_cnt, 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_req", tx_req, 0);
    chk("rst_valid", tx_data_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_len", tx_len, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_off", tx_off, 0);
    chk("rst_last", tx_last, 1);

    // Four pixels, ack on the third REQ cycle
    clear_mon();
    start_frame(32'd4);
    chk("s1_req", tx_req, 1);
    chk("s1_len", tx_len, 32'd4);
    pixel_valid = 1'b1;
    pixel_in = 32'h11; tick();
    pixel_in = 32'h22; tick();
    chk("s1_req_novalid", tx_data_valid, 0);
    pixel_in = 32'h33; tx_ack = 1'b1; tick();
    tx_ack = 1'b0;
    chk("s1_req_drop", tx_req, 0);
    chk("s1_head0", tx_data, 64'h00000022_00000011);
    pixel_in = 32'h44; tx_data_ren = 1'b1; tick();
    pixel_valid = 1'b0;
    chk("s1_head1", tx_data, 64'h00000044_00000033);
    wait_done("s1_done");
    repeat (3) tick();
    chk("s1_nwords", words.size(), 2);
    chk("s1_w0", getw(0), 64'h00000022_00000011);
    chk("s1_w1", getw(1), 64'h00000044_00000033);
    chk("s1_done_once", done_cnt, 1);
    chk("s1_ovf", overflow, 0);

    // Odd total, info_valid during REQ ignored
    do_reset();
    clear_mon();
    start_frame(32'd3);
    chk("s2_len", tx_len, 32'd4);
    start_frame(32'd100);
    chk("s2_len_hold", tx_len, 32'd4);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    tx_data_ren = 1'b1;
    pixel_valid = 1'b1;
    pixel_in = 32'hA; tick();
    pixel_in = 32'hB; tick();
    pixel_in = 32'hC; tick();
    pixel_valid = 1'b0;
    wait_done("s2_done");
    chk("s2_nwords", words.size(), 2);
    chk("s2_w0", getw(0), 64'h0000000B_0000000A);
    chk("s2_w1", getw(1), 64'h00000000_0000000C);
    chk("s2_ovf", overflow, 0);

    // FIFO saturation with no reads
    do_reset();
    clear_mon();
    start_frame(32'd64);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    for (int i = 0; i < 64; i++) begin
      pixel_valid = 1'b1;
      pixel_in = i + 1;
      tick();
    end
    pixel_valid = 1'b0;
    tick();
    chk("s3_ovf", overflow, 1);
    chk("s3_valid", tx_data_valid, 1);
    chk("s3_head", tx_data, 64'h00000002_00000001);
    tx_data_ren = 1'b1;
    repeat (40) tick();
    chk("s3_nwords", words.size(), 16);
    for (int k = 0; k < 16; k++) begin
      logic [31:0] lo;
      logic [31:0] hi;
      lo = 2 * k + 1;
      hi = 2 * k + 2;
      chk($sformatf("s3_w%0d", k), getw(k), {hi, lo});
    end
    chk("s3_no_done", done_cnt, 0);
    chk("s3_drained", tx_data_valid, 0);

    // Pixels while idle
    do_reset();
    clear_mon();
    pixel_in = 32'h5; pixel_valid = 1'b1;
    tick(); tick();
    pixel_valid = 1'b0;
    chk("s4_ovf_set", overflow, 1);
    chk("s4_valid", tx_data_valid, 0);
    start_frame(32'd2);
    chk("s4_ovf_clr", overflow, 0);
    chk("s4_req", tx_req, 1);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    chk("s4_fifo_empty", tx_data_valid, 0);

    // Reset mid-stream with two words queued
    do_reset();
    clear_mon();
    start_frame(32'd8);
    tx_ack = 1'b1; tick(); tx_ack = 1'b0;
    pixel_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pixel_in = 32'h100 + i;
      tick();
    end
    pixel_valid = 1'b0;
    chk("s5_queued", tx_data_valid, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s5_valid", tx_data_valid, 0);
    chk("s5_req", tx_req, 0);
    chk("s5_done", frame_done, 0);
    chk("s5_len", tx_len, 0);
    start_frame(32'd2);
    chk("s5_idle", tx_req, 1);
    chk("s5_no_done", done_cnt, 0);

    // Zero-length frame
    do_reset();
    clear_mon();
    start_frame(32'd0);
    repeat (6) tick();
    chk("s6_req_seen", req_seen, 0);
    chk("s6_done", done_cnt, 0);
    chk("s6_len", tx_len, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/output_packer.md
OUTPUT_PACKER -- requirements
Module: output_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, number of 64-bit entries in the internal word FIFO (power of two, >=4).
REQ-002 Parameter PIX_W, default 32, width of one output pixel word; fixed at 32 for the RIFFA 64-bit channel.
REQ-003 clock  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 info_valid  input  1  one-cycle pulse; latches total_pixels and starts a frame.
REQ-006 total_pixels  input  32  unsigned count of pixels in the output frame.
REQ-007 pixel_in  input  32  pixel word from the filter stage.
REQ-008 pixel_valid  input  1  pixel_in valid this cycle; no backpressure toward the filter stage.
REQ-009 tx_req  output  1  RIFFA TX transaction request.
REQ-010 tx_ack  input  1  RIFFA acknowledge of tx_req.
REQ-011 tx_len  output  32  transaction length in 32-bit words.
REQ-012 tx_off  output  31  transaction offset, tied to 0.
REQ-013 tx_last  output  1  tied to 1.
REQ-014 tx_data  output  64  packed pixel pair.
REQ-015 tx_data_valid  output  1  tx_data holds a valid word.
REQ-016 tx_data_ren  input  1  RIFFA consumes tx_data when tx_data_valid is also high.
REQ-017 frame_done  output  1  one-cycle pulse after the last word transfers.
REQ-018 overflow  output  1  sticky flag: a pixel was dropped.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, STREAM and DONE.
REQ-020 IDLE: info_valid with total_pixels>0 SHALL latch the count, compute tx_len = total_pixels rounded up to even, clear overflow, and move to REQ on the next edge.
REQ-021 IDLE: info_valid with total_pixels==0 SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-022 REQ: tx_req SHALL be high and tx_len SHALL be stable; when tx_ack is sampled high, the FSM SHALL move to STREAM and tx_req SHALL drop on the same edge.
REQ-023 STREAM: tx_data_valid SHALL equal FIFO non-empty; a word transfers on each edge where tx_data_valid and tx_data_ren are both high.
REQ-024 When the transferred-word count reaches tx_len/2 on a transfer edge, the FSM SHALL enter DONE; DONE SHALL assert frame_done for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-025 The block SHALL accept pixels in REQ and STREAM only; pixels in IDLE or DONE SHALL be dropped and SHALL set overflow.
REQ-026 Pixels beyond the latched total_pixels SHALL be dropped and SHALL set overflow.
REQ-027 Packing: the even-indexed pixel (0,2,...) SHALL be held in a low-half register; the odd-indexed pixel SHALL write {pixel_in, low_half} into the FIFO on the same edge.
REQ-028 If total_pixels is odd, the final pixel SHALL be written as {32'h0, pixel_in} on the edge it is accepted.
REQ-029 The FIFO SHALL be show-ahead, and a written word SHALL appear on tx_data with tx_data_valid high on the cycle after the write edge.
REQ-030 A simultaneous FIFO write and read SHALL be permitted when the FIFO is full or when it holds one entry; a write into an empty FIFO SHALL NOT be read on the same edge.
REQ-031 If the FIFO is full with no read that cycle and a word write is due, the word SHALL be discarded, overflow SHALL be set, and the pixel count SHALL still advance.
REQ-032 Word order on tx_data SHALL match pixel arrival order, with no reordering and no duplication.
REQ-033 The pixel counter and word counter SHALL be 32 bits wide and SHALL NOT wrap within a frame.
REQ-034 info_valid outside IDLE SHALL be ignored.

Reset
REQ-035 While reset is high, on every edge: the FSM SHALL be in IDLE, the FIFO SHALL be empty, all counters and the low-half register SHALL be 0, and tx_req, tx_data_valid, frame_done and overflow SHALL be 0.
REQ-036 tx_len and tx_data SHALL be 0 after reset.
REQ-037 Reset asserted mid-frame SHALL abandon the frame without emitting frame_done.

Verification
REQ-038 Scenario: total=4, tx_ack after 3 cycles, pixels 0x11,0x22,0x33,0x44, tx_data_ren=1 -> tx_len=4; words 0x00000022_00000011 then 0x00000044_00000033; one frame_done pulse; overflow=0.
REQ-039 Scenario: total=3, pixels 0xA,0xB,0xC -> tx_len=4; second word 0x00000000_0000000C; frame_done after 2 transfers.
REQ-040 Scenario: total=64, tx_data_ren=0 throughout STREAM -> FIFO holds 16 words; pixels 33..64 dropped; overflow=1; releasing ren delivers exactly 16 words and no frame_done.
REQ-041 Scenario: pixel_valid pulses in IDLE before info_valid -> overflow=1, FIFO empty; the next info_valid clears overflow.
REQ-042 Scenario: reset asserted during STREAM with 2 words queued -> on the next cycle tx_data_valid=0, tx_req=0, FSM in IDLE, no frame_done.
REQ-043 Scenario: info_valid with total=0 -> tx_req never asserted; frame_done=0.
